// File: rtl/sobel_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_result_writer
//  Description : Output sink of the Sobel datapath. Accepts one gradient
//                magnitude per valid window position, optionally binarises
//                it, buffers it in a 2-entry FIFO and writes it to the
//                output image region in row-major order. Pulses frame_done
//                for one cycle when the whole (width-2)x(length-2) frame
//                has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_result_writer #(
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 12,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  length,
  input  logic [ADDR_W-1:0] initial_addr_w,
  input  logic              thresh_en,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              g_valid,
  input  logic [PIX_W-1:0]  g,
  output logic              g_ready,
  input  logic              mem_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = 2 * DIM_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Frame parameters captured at an accepted start
  logic [CNT_W-1:0]  total_q, total_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              thr_en_q, thr_en_d;
  logic [PIX_W-1:0]  thr_q, thr_d;

  // Progress counters
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic [CNT_W-1:0]  written_q, written_d;

  // Two-entry FIFO
  logic [PIX_W-1:0]  fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q, count_d;

  // Registered write port
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;

  // Combinational helpers
  logic [DIM_W-1:0]  w_width_m2, w_length_m2;
  logic [CNT_W-1:0]  w_total;
  logic              w_start_ok;
  logic              w_active;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [PIX_W-1:0]  w_push_data;

  // Frame size; anything narrower or shorter than a 3x3 window yields no output
  assign w_width_m2  = width - DIM_W'(2);
  assign w_length_m2 = length - DIM_W'(2);
  assign w_total     = ((width < DIM_W'(3)) || (length < DIM_W'(3))) ? '0 :
                       CNT_W'(w_width_m2) * CNT_W'(w_length_m2);

  assign w_start_ok  = (state_q == S_IDLE) && start;
  assign w_active    = (state_q == S_RUN) || (state_q == S_DRAIN);

  // Accept only while running, with room in the FIFO, and before the frame is full
  assign w_ready     = (state_q == S_RUN) && (count_q != 2'd2) && (accepted_q < total_q);
  assign w_push      = g_valid && w_ready;

  // Pop whenever there is data and the memory can take a write this cycle
  assign w_pop       = w_active && (count_q != 2'd0) && !mem_busy;

  // Binarisation uses the threshold settings latched for this frame
  assign w_push_data = thr_en_q ? ((g >= thr_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}}) : g;

  // Next-state, parameter capture and counter update
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    base_d     = base_q;
    thr_en_d   = thr_en_q;
    thr_d      = thr_q;
    accepted_d = accepted_q;
    written_d  = written_q;

    if (w_active) begin
      accepted_d = accepted_q + CNT_W'(w_push);
      written_d  = written_q + CNT_W'(w_pop);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d    = w_total;
          base_d     = initial_addr_w;
          thr_en_d   = thresh_en;
          thr_d      = threshold;
          accepted_d = '0;
          written_d  = '0;
          state_d    = (w_total == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accepted_q == total_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count_q == 2'd0) && (written_q == total_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO occupancy follows pushes and pops; simultaneous push/pop keeps it level
  always_comb begin
    count_d = count_q;
    if (w_start_ok) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Control state, frame parameters and counters
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= S_IDLE;
      total_q    <= '0;
      base_q     <= '0;
      thr_en_q   <= 1'b0;
      thr_q      <= '0;
      accepted_q <= '0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      base_q     <= base_d;
      thr_en_q   <= thr_en_d;
      thr_q      <= thr_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (w_start_ok) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (w_push) begin
          fifo_q[wr_ptr_q] <= w_push_data;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (w_pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  // Write port: one strobe per pop, address is base plus words already written
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= w_pop;
      if (w_pop) begin
        wr_addr_q <= base_q + written_q[ADDR_W-1:0];
        wr_data_q <= fifo_q[rd_ptr_q];
      end
    end
  end

  assign g_ready    = w_ready;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sobel_result_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_result_writer
//  Description : Directed bench for sobel_result_writer with a scoreboard
//                model of the expected write stream and literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_result_writer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [11:0] width;
  logic [11:0] length;
  logic [7:0]  initial_addr_w;
  logic        thresh_en;
  logic [7:0]  threshold;
  logic        g_valid;
  logic [7:0]  g;
  logic        g_ready;
  logic        mem_busy;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  sobel_result_writer #(.ADDR_W(8), .DIM_W(12), .PIX_W(8)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .width          (width),
    .length         (length),
    .initial_addr_w (initial_addr_w),
    .thresh_en      (thresh_en),
    .threshold      (threshold),
    .g_valid        (g_valid),
    .g              (g),
    .g_ready        (g_ready),
    .mem_busy       (mem_busy),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame description owned by the stimulus process
  int         m_gen   = 0;
  int         m_total = 0;
  logic [7:0] m_base  = 8'h00;
  logic       m_ten   = 1'b0;
  logic [7:0] m_thr   = 8'h00;

  // Accepted samples, transformed as the memory must see them
  int         acc_gen = 0;
  int         m_acc   = 0;
  logic [7:0] exp_d [64];
  logic       last_mb = 1'b0;

  always @(posedge clk) begin
    if (acc_gen != m_gen) begin
      acc_gen = m_gen;
      m_acc   = 0;
    end
    last_mb = mem_busy;
    if (g_valid && g_ready) begin
      exp_d[m_acc % 64] = m_ten ? ((g >= m_thr) ? 8'hFF : 8'h00) : g;
      m_acc++;
    end
  end

  // Output checker: every write must be the next expected word at the next address
  int         wr_gen = 0;
  int         m_wr   = 0;
  int         log_n  = 0;
  logic [7:0] log_a [64];
  logic [7:0] log_d [64];
  logic [7:0] ea;

  always @(negedge clk) begin
    if (wr_gen != m_gen) begin
      wr_gen = m_gen;
      m_wr   = 0;
      log_n  = 0;
    end
    if (wr_en) begin
      chk("wr_within_frame", 32'(m_wr < m_total), 1);
      chk("wr_after_accept", 32'(m_wr < m_acc), 1);
      chk("wr_not_when_mem_busy", 32'(last_mb), 0);
      ea = m_base + 8'(m_wr);
      chk("wr_addr", 32'(wr_addr), 32'(ea));
      chk("wr_data", 32'(wr_data), 32'(exp_d[m_wr % 64]));
      log_a[log_n % 64] = wr_addr;
      log_d[log_n % 64] = wr_data;
      log_n++;
      m_wr++;
    end
    if (g_ready) begin
      chk("g_ready_has_room", 32'(((m_acc - m_wr) < 2) && (m_acc < m_total)), 1);
    end
    if (frame_done) begin
      chk("done_all_written", 32'(m_wr), 32'(m_total));
      chk("done_all_accepted", 32'(m_acc), 32'(m_total));
      chk("done_busy", 32'(busy), 1);
    end
  end

  // Issue a start with the model's view of the frame; called at a negedge
  task automatic begin_frame(input int w, input int l, input logic [7:0] base,
                             input logic te, input logic [7:0] th, input int tot);
    m_total        = tot;
    m_base         = base;
    m_ten          = te;
    m_thr          = th;
    m_gen++;
    width          = 12'(w);
    length         = 12'(l);
    initial_addr_w = base;
    thresh_en      = te;
    threshold      = th;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  // Present one sample and hold it until the writer takes it
  task automatic send(input logic [7:0] v);
    logic acc;
    logic ok;
    ok      = 1'b0;
    g_valid = 1'b1;
    g       = v;
    for (int t = 0; t < 100; t++) begin
      acc = g_ready;
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 32'(ok), 1);
  endtask

  // Count negedges until frame_done is seen
  task automatic wait_done(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (frame_done) begin
        n = i;
        break;
      end
    end
    chk("frame_done_seen", 32'(n > 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    logic [7:0] thr_in  [4];
    logic [7:0] thr_out [4];
    logic [7:0] wrap_a  [3];

    thr_in  = '{8'h7F, 8'h80, 8'hFF, 8'h00};
    thr_out = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    wrap_a  = '{8'hFE, 8'hFF, 8'h00};

    n_rst = 1'b1; start = 1'b0; width = '0; length = '0; initial_addr_w = '0;
    thresh_en = 1'b0; threshold = '0; g_valid = 1'b0; g = '0; mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_g_ready", 32'(g_ready), 0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_g_ready", 32'(g_ready), 0);

    // Frame 1: 5x4 -> 6 writes, back-to-back samples, no stalls
    begin_frame(5, 4, 8'h10, 1'b0, 8'h00, 6);
    chk("f1_busy_run", 32'(busy), 1);
    send(8'd1);
    chk("f1_no_write_yet", 32'(wr_en), 0);
    send(8'd2);
    chk("f1_first_write", 32'(wr_en), 1);
    chk("f1_first_addr", 32'(wr_addr), 32'h10);
    chk("f1_first_data", 32'(wr_data), 32'h01);
    for (int k = 3; k <= 6; k++) send(8'(k));
    g_valid = 1'b0;
    wait_done(20, n);
    chk("f1_done_latency", 32'(n), 2);
    chk("f1_busy_in_done", 32'(busy), 1);
    @(negedge clk);
    chk("f1_done_one_cycle", 32'(frame_done), 0);
    chk("f1_busy_after", 32'(busy), 0);
    chk("f1_write_count", 32'(log_n), 6);
    chk("f1_last_addr", 32'(log_a[5]), 32'h15);
    chk("f1_last_data", 32'(log_d[5]), 32'h06);

    // Frame 2: memory stalls for 5 cycles after the first sample
    begin_frame(5, 4, 8'h10, 1'b0, 8'h00, 6);
    send(8'd1);
    mem_busy = 1'b1;
    seen = 1'b0;
    fork
      begin
        for (int k = 2; k <= 6; k++) send(8'(k));
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (!g_ready) seen = 1'b1;
        end
        mem_busy = 1'b0;
      end
    join
    g_valid = 1'b0;
    wait_done(40, n);
    chk("f2_backpressure", 32'(seen), 1);
    chk("f2_write_count", 32'(log_n), 6);
    for (int i = 0; i < 6; i++) begin
      chk("f2_order_data", 32'(log_d[i]), 32'(i + 1));
      chk("f2_order_addr", 32'(log_a[i]), 32'(8'h10 + i));
    end
    @(negedge clk);

    // Frame 3: binarised output
    begin_frame(4, 4, 8'h40, 1'b1, 8'h80, 4);
    for (int k = 0; k < 4; k++) send(thr_in[k]);
    g_valid = 1'b0;
    wait_done(20, n);
    for (int k = 0; k < 4; k++) chk("f3_thresh_data", 32'(log_d[k]), 32'(thr_out[k]));
    @(negedge clk);

    // Frame 4: address wrap
    begin_frame(5, 3, 8'hFE, 1'b0, 8'h00, 3);
    for (int k = 0; k < 3; k++) send(8'(8'hA0 + k));
    g_valid = 1'b0;
    wait_done(20, n);
    for (int k = 0; k < 3; k++) chk("f4_wrap_addr", 32'(log_a[k]), 32'(wrap_a[k]));
    @(negedge clk);

    // Frame 5: degenerate size, no writes, immediate completion
    begin_frame(2, 10, 8'h00, 1'b0, 8'h00, 0);
    chk("f5_done_now", 32'(frame_done), 1);
    chk("f5_no_write", 32'(wr_en), 0);
    @(negedge clk);
    chk("f5_done_cleared", 32'(frame_done), 0);
    chk("f5_idle", 32'(busy), 0);
    chk("f5_write_count", 32'(log_n), 0);

    // Frame 6: start pulsed mid-frame with different settings must be ignored
    begin_frame(4, 4, 8'h60, 1'b0, 8'h00, 4);
    send(8'h09);
    send(8'h08);
    width = 12'd20; length = 12'd20; initial_addr_w = 8'h99;
    thresh_en = 1'b1; threshold = 8'h01; start = 1'b1;
    send(8'h07);
    start = 1'b0;
    send(8'h06);
    g_valid = 1'b0;
    wait_done(20, n);
    chk("f6_write_count", 32'(log_n), 4);
    chk("f6_last_addr", 32'(log_a[3]), 32'h63);
    chk("f6_last_data", 32'(log_d[3]), 32'h06);
    @(negedge clk);

    // Frame 7: reset in the middle of a frame
    begin_frame(5, 4, 8'h20, 1'b0, 8'h00, 6);
    for (int k = 1; k <= 4; k++) send(8'(k));
    g_valid = 1'b0;
    for (int t = 0; t < 10 && log_n < 3; t++) @(negedge clk);
    chk("f7_three_written", 32'(log_n >= 3), 1);
    #2;
    n_rst   = 1'b1;
    m_total = 0;
    m_gen++;
    #1;
    chk("f7_rst_wr_en", 32'(wr_en), 0);
    chk("f7_rst_wr_addr", 32'(wr_addr), 0);
    chk("f7_rst_wr_data", 32'(wr_data), 0);
    chk("f7_rst_busy", 32'(busy), 0);
    chk("f7_rst_done", 32'(frame_done), 0);
    chk("f7_rst_g_ready", 32'(g_ready), 0);
    repeat (2) @(negedge clk);
    #2;
    n_rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("f7_no_writes_after", 32'(log_n), 0);

    // Frame 8: full frame after the reset
    begin_frame(5, 4, 8'h30, 1'b0, 8'h00, 6);
    for (int k = 0; k < 6; k++) send(8'(8'h11 + k));
    g_valid = 1'b0;
    wait_done(20, n);
    chk("f8_write_count", 32'(log_n), 6);
    chk("f8_first_addr", 32'(log_a[0]), 32'h30);
    chk("f8_first_data", 32'(log_d[0]), 32'h11);
    chk("f8_last_addr", 32'(log_a[5]), 32'h35);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
